// File: rtl/instr_cycle_seq.sv
// instr_cycle_seq: LVDC instruction-cycle sequencer (fetch, HOP load, execute, stall, interrupt, halt)
// Ports: clk/rstn (sync active-low); run, haltreq, intreq, inten, opc in;
//        phase, bt, state, wtend, ldop, hopld, pcinc, intack, exec, stallo, mdbusy, mdcnt out.
module instr_cycle_seq #(
    parameter int BITS    = 14,
    parameter int MPY_CYC = 4,
    parameter int DIV_CYC = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       run,
    input  logic       haltreq,
    input  logic       intreq,
    input  logic       inten,
    input  logic [3:0] opc,
    output logic [1:0] phase,
    output logic [3:0] bt,
    output logic [2:0] state,
    output logic       wtend,
    output logic       ldop,
    output logic       hopld,
    output logic       pcinc,
    output logic       intack,
    output logic       exec,
    output logic       stallo,
    output logic       mdbusy,
    output logic [3:0] mdcnt
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HOPX  = 3'd3,
        S_INTX  = 3'd4,
        S_STALL = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    localparam logic [3:0] OP_HOP  = 4'b0000;
    localparam logic [3:0] OP_MPY  = 4'b0001;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MPH  = 4'b0101;
    localparam logic [3:0] BT_LAST = 4'(BITS - 1);

    state_t     st, st_nx, leave;
    logic [3:0] opl, md_nx;
    logic       md_wait;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase <= 2'd0;
            bt    <= 4'd0;
            st    <= S_IDLE;
            mdcnt <= 4'd0;
            opl   <= 4'd0;
        end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) bt <= (bt == BT_LAST) ? 4'd0 : bt + 4'd1;
            st    <= st_nx;
            mdcnt <= md_nx;
            if (ldop) opl <= opc;
        end
    end

    always_comb begin
        wtend   = (bt == BT_LAST) && (phase == 2'd3);
        ldop    = wtend && (st == S_FETCH);
        hopld   = wtend && (st == S_HOPX);
        pcinc   = wtend && (st == S_EXEC);
        intack  = wtend && (st == S_INTX);
        exec    = (st == S_EXEC);
        stallo  = (st == S_STALL);
        mdbusy  = (mdcnt != 4'd0);
        state   = st;
        // Stall decision uses the opcode arriving on this LDOP edge, not the old latch.
        md_wait = (opc == OP_MPY) || (opc == OP_DIV) || (opc == OP_MPH);
        leave   = haltreq ? S_HALT : (intreq && inten) ? S_INTX : S_FETCH;
        // A new MPY/DIV load wins over the background countdown.
        md_nx   = !wtend ? mdcnt :
                  (st == S_EXEC && opl == OP_MPY) ? 4'(MPY_CYC) :
                  (st == S_EXEC && opl == OP_DIV) ? 4'(DIV_CYC) :
                  mdbusy ? mdcnt - 4'd1 : mdcnt;
        st_nx   = st;
        if (wtend)
            case (st)
                S_IDLE:         st_nx = run ? S_FETCH : S_IDLE;
                S_FETCH:        st_nx = (md_wait && mdcnt > 4'd1) ? S_STALL :
                                        (opc == OP_HOP) ? S_HOPX : S_EXEC;
                S_STALL:        st_nx = (mdcnt <= 4'd1) ? S_EXEC : S_STALL;
                S_EXEC, S_HOPX: st_nx = leave;
                S_INTX:         st_nx = S_FETCH;
                S_HALT:         st_nx = (run && !haltreq) ? S_FETCH : S_HALT;
                default:        st_nx = S_IDLE;
            endcase
    end
endmodule

// File: tb/tb_instr_cycle_seq.sv
// tb_instr_cycle_seq: randomized and directed checks of instr_cycle_seq against a word-level model
module tb_instr_cycle_seq;
    localparam int BITS = 14, MPY_CYC = 4, DIV_CYC = 8, LAST = 4 * BITS - 1;
    localparam int IDLE = 0, FETCH = 1, EXEC = 2, HOPX = 3, INTX = 4, STALL = 5, HALT = 6;

    logic       clk = 1'b0, rstn = 1'b0, run = 1'b0, haltreq = 1'b0, intreq = 1'b0, inten = 1'b0;
    logic [3:0] opc = 4'd0;
    logic [1:0] phase;
    logic [3:0] bt, mdcnt;
    logic [2:0] state;
    logic       wtend, ldop, hopld, pcinc, intack, exec, stallo, mdbusy;

    int         checks = 0, passes = 0, stray = 0, pos = 0, m_st = IDLE, m_md = 0;
    logic [3:0] m_op = 4'd0;
    logic [6:0] act_p, exp_p;

    instr_cycle_seq #(.BITS(BITS), .MPY_CYC(MPY_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rstn(rstn), .run(run), .haltreq(haltreq), .intreq(intreq), .inten(inten),
        .opc(opc), .phase(phase), .bt(bt), .state(state), .wtend(wtend), .ldop(ldop),
        .hopld(hopld), .pcinc(pcinc), .intack(intack), .exec(exec), .stallo(stallo),
        .mdbusy(mdbusy), .mdcnt(mdcnt)
    );

    always #5 clk = ~clk;

    // Advance exactly one word time from the current negedge, checking counter
    // position every clock and applying the word-level model at the boundary.
    task automatic word();
        bit done = 0;
        int nst, nmd;
        while (!done) begin
            if (phase !== 2'(pos % 4) || bt !== 4'(pos / 4) || wtend !== (pos == LAST)) stray++;
            if (pos == LAST) begin
                act_p = {ldop, hopld, pcinc, intack, exec, stallo, wtend};
                exp_p = {m_st == FETCH, m_st == HOPX, m_st == EXEC, m_st == INTX,
                         m_st == EXEC, m_st == STALL, 1'b1};
                nmd = (m_st == EXEC && m_op == 4'd1) ? MPY_CYC :
                      (m_st == EXEC && m_op == 4'd3) ? DIV_CYC : (m_md > 0 ? m_md - 1 : 0);
                case (m_st)
                    IDLE:       nst = run ? FETCH : IDLE;
                    FETCH: begin
                        m_op = opc;
                        nst = (opc inside {4'd1, 4'd3, 4'd5} && m_md > 1) ? STALL :
                              (opc == 4'd0) ? HOPX : EXEC;
                    end
                    STALL:      nst = (m_md <= 1) ? EXEC : STALL;
                    EXEC, HOPX: nst = haltreq ? HALT : (intreq && inten) ? INTX : FETCH;
                    INTX:       nst = FETCH;
                    default:    nst = (run && !haltreq) ? FETCH : HALT;
                endcase
                m_st = nst;
                m_md = nmd;
                done = 1;
            end else if (ldop | hopld | pcinc | intack) stray++;
            @(posedge clk);
            pos = (pos == LAST) ? 0 : pos + 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({state, mdcnt, phase, bt} !== 13'd0 ||
            {ldop, hopld, pcinc, intack, exec, stallo, wtend, mdbusy} !== 8'd0)
            $display("FAIL reset: state=%0d mdcnt=%0d phase=%0d bt=%0d pulses=%b, want all 0",
                     state, mdcnt, phase, bt, {ldop, hopld, pcinc, intack, exec, stallo, wtend, mdbusy});
        else passes++;
        rstn = 1'b1;
        pos = 0; m_st = IDLE; m_md = 0; m_op = 4'd0;
    endtask

    task automatic test_basic_fetch();
        logic [2:0] want [3] = '{3'd1, 3'd2, 3'd1};
        run = 1'b1; opc = 4'b0111; stray = 0;
        for (int w = 0; w < 3; w++) begin
            word();
            checks++;
            if (act_p !== exp_p || state !== 3'(m_st) || state !== want[w] || mdcnt !== 4'(m_md))
                $display("FAIL basic_fetch w%0d: pulses=%b state=%0d mdcnt=%0d, want pulses=%b state=%0d mdcnt=%0d",
                         w, act_p, state, mdcnt, exp_p, want[w], m_md);
            else passes++;
        end
        checks++;
        if (stray !== 0) $display("FAIL basic_timing: stray=%0d, want 0", stray);
        else passes++;
    endtask

    task automatic test_hop();
        opc = 4'b0000; haltreq = 1'b0; intreq = 1'b0;
        for (int w = 0; w < 2; w++) begin
            run = 1'($urandom);
            word();
            checks++;
            if (act_p !== exp_p || state !== 3'(m_st) || state !== ((w == 0) ? 3'd3 : 3'd1))
                $display("FAIL hop w%0d: pulses=%b state=%0d, want pulses=%b state=%0d",
                         w, act_p, state, exp_p, m_st);
            else passes++;
        end
        checks++;
        if (act_p !== 7'b0100001) $display("FAIL hop_pulse: pulses=%b, want 0100001", act_p);
        else passes++;
    endtask

    task automatic test_mpy_stall();
        logic [3:0] ops  [14] = '{4'd1, 4'hF, 4'd7, 4'hF, 4'd5, 4'hF, 4'hF, 4'd1, 4'hF, 4'd1, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [2:0] wst  [14] = '{3'd2, 3'd1, 3'd2, 3'd1, 3'd5, 3'd2, 3'd1, 3'd2, 3'd1, 3'd5, 3'd5, 3'd5, 3'd2, 3'd1};
        logic [3:0] wmd  [14] = '{4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4};
        haltreq = 1'b0; intreq = 1'b0;
        for (int w = 0; w < 14; w++) begin
            opc = (ops[w] == 4'hF) ? 4'($urandom_range(6, 15)) : ops[w];
            run = 1'($urandom);
            word();
            checks++;
            if (act_p !== exp_p || state !== wst[w] || mdcnt !== wmd[w] || state !== 3'(m_st) ||
                mdcnt !== 4'(m_md) || mdbusy !== (wmd[w] != 4'd0))
                $display("FAIL mpy_stall w%0d: pulses=%b state=%0d mdcnt=%0d, want pulses=%b state=%0d mdcnt=%0d",
                         w, act_p, state, mdcnt, exp_p, wst[w], wmd[w]);
            else passes++;
        end
    endtask

    task automatic test_interrupt();
        logic [6:0] wp [5] = '{7'b1000001, 7'b0010101, 7'b0001001, 7'b1000001, 7'b0010101};
        logic [2:0] ws [5] = '{3'd2, 3'd4, 3'd1, 3'd2, 3'd1};
        opc = 4'b0111; intreq = 1'b1; haltreq = 1'b0;
        for (int w = 0; w < 5; w++) begin
            inten = (w < 3);
            word();
            checks++;
            if (act_p !== wp[w] || act_p !== exp_p || state !== ws[w] || state !== 3'(m_st))
                $display("FAIL interrupt w%0d: pulses=%b state=%0d, want pulses=%b state=%0d",
                         w, act_p, state, wp[w], ws[w]);
            else passes++;
        end
        intreq = 1'b0; inten = 1'b0;
    endtask

    task automatic test_halt();
        opc = 4'b0011; run = 1'b1;
        word();
        haltreq = 1'b1; intreq = 1'b1; inten = 1'b1;
        word();
        checks++;
        if (state !== 3'd6 || mdcnt !== 4'd8 || act_p !== 7'b0010101 || act_p !== exp_p)
            $display("FAIL halt_entry: state=%0d mdcnt=%0d pulses=%b, want state=6 mdcnt=8 pulses=0010101",
                     state, mdcnt, act_p);
        else passes++;
        for (int w = 0; w < 9; w++) begin
            if (w == 8) begin haltreq = 1'b0; run = 1'b0; end
            word();
            checks++;
            if (state !== 3'd6 || mdcnt !== 4'((w < 8) ? 7 - w : 0) || act_p !== 7'b0000001 ||
                act_p !== exp_p || mdcnt !== 4'(m_md))
                $display("FAIL halt_hold w%0d: state=%0d mdcnt=%0d pulses=%b, want state=6 mdcnt=%0d pulses=0000001",
                         w, state, mdcnt, act_p, (w < 8) ? 7 - w : 0);
            else passes++;
        end
        run = 1'b1; intreq = 1'b0; inten = 1'b0;
        word();
        checks++;
        if (state !== 3'd1 || state !== 3'(m_st)) $display("FAIL halt_exit: state=%0d, want 1", state);
        else passes++;
    endtask

    task automatic test_mid_reset();
        opc = 4'b0001;
        repeat (3) word();
        checks++;
        if (state !== 3'd5 || mdcnt !== 4'd3 || state !== 3'(m_st))
            $display("FAIL midrst_setup: state=%0d mdcnt=%0d, want state=5 mdcnt=3", state, mdcnt);
        else passes++;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({state, mdcnt, phase, bt} !== 13'd0 ||
            {ldop, hopld, pcinc, intack, exec, stallo, wtend, mdbusy} !== 8'd0)
            $display("FAIL midrst: state=%0d mdcnt=%0d phase=%0d bt=%0d pulses=%b, want all 0",
                     state, mdcnt, phase, bt, {ldop, hopld, pcinc, intack, exec, stallo, wtend, mdbusy});
        else passes++;
        rstn = 1'b1;
        pos = 0; m_st = IDLE; m_md = 0; m_op = 4'd0;
        run = 1'b1; opc = 4'b0111;
        word();
        checks++;
        if (state !== 3'd1 || mdcnt !== 4'd0 || act_p !== exp_p)
            $display("FAIL midrst_restart: state=%0d mdcnt=%0d pulses=%b, want state=1 mdcnt=0 pulses=%b",
                     state, mdcnt, act_p, exp_p);
        else passes++;
    endtask

    task automatic test_random();
        stray = 0;
        for (int w = 0; w < 100; w++) begin
            opc = 4'($urandom_range(0, 7));
            if (opc > 4'd5) opc = 4'($urandom);
            run     = 1'($urandom);
            haltreq = ($urandom_range(0, 4) == 0);
            intreq  = 1'($urandom);
            inten   = 1'($urandom);
            word();
            checks++;
            if (act_p !== exp_p || state !== 3'(m_st) || mdcnt !== 4'(m_md) || mdbusy !== (m_md != 0))
                $display("FAIL random w%0d: pulses=%b state=%0d mdcnt=%0d, want pulses=%b state=%0d mdcnt=%0d",
                         w, act_p, state, mdcnt, exp_p, m_st, m_md);
            else passes++;
        end
        checks++;
        if (stray !== 0) $display("FAIL random_timing: stray=%0d, want 0", stray);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hop();
        test_mpy_stall();
        test_interrupt();
        test_halt();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/instr_cycle_seq.md
Name: instr_cycle_seq

Overview:
- Instruction-cycle sequencer for the LVDC CPU. It owns the phase and bit-time counters and steps each instruction through fetch, HOP-constant load, execute, stall and interrupt entry.
- It strobes the op code register load (LDOP) and the HOP-constant load (HOPLD), and tracks the background multiply/divide unit.
- It sits between the timing generator and the op code register and PC logic.

Parameters:
BITS, 14, bit times per word time (2..16)
MPY_CYC, 4, word times MPY occupies the multiply/divide unit (1..15)
DIV_CYC, 8, word times DIV occupies the multiply/divide unit (1..15)

Ports:
CLK  in  1  single system clock
RSTN  in  1  reset, synchronous, active-low
RUN  in  1  leave IDLE/HALT at next word boundary
HALTREQ  in  1  halt after current instruction
INTREQ  in  1  interrupt request
INTEN  in  1  interrupt enable
OPC  in  4  opcode {OP4,OP3,OP2,OP1}; sampled on the LDOP clock
PHASE  out  2  phase within bit time, 0..3
BT  out  4  bit-time counter, 0..BITS-1
STATE  out  3  IDLE=0 FETCH=1 EXEC=2 HOPX=3 INTX=4 STALL=5 HALT=6
WTEND  out  1  one-clock pulse on last clock of each word time
LDOP  out  1  one-clock pulse: op code register load
HOPLD  out  1  one-clock pulse: HOP constant load
PCINC  out  1  one-clock pulse: increment PC
INTACK  out  1  one-clock pulse: interrupt taken
EXEC  out  1  level, high while STATE=EXEC
STALLO  out  1  level, high while STATE=STALL
MDBUSY  out  1  MDCNT != 0
MDCNT  out  4  remaining multiply/divide word times

Behaviour:
- Clock and reset:
  - Single clock CLK. RSTN is synchronous and active-low.
  - Any edge with RSTN=0 forces all of the following, including mid-instruction; a pending MPY/DIV is discarded:
    - PHASE=0, BT=0, STATE=IDLE, MDCNT=0.
    - Internal opcode latch = 0.
    - All pulse and level outputs = 0.
- Timing counters:
  - PHASE increments every clock and wraps 3->0.
  - BT increments when PHASE=3 and wraps BITS-1->0.
  - Counters free-run in every state from reset release.
  - WTEND = (BT==BITS-1 && PHASE==3). This is combinational from the registered counters, so one word time = 4*BITS clocks (56 by default).
- State changes and action pulses:
  - All state changes occur only on the WTEND clock.
  - LDOP, HOPLD, PCINC and INTACK are asserted only during the WTEND clock of the owning state.
- Opcodes: HOP=0000, MPY=0001, DIV=0011, MPH=0101. All other opcodes are ordinary single-word-time instructions.
- Per-state behaviour:
  - IDLE: at WTEND, RUN=1 -> FETCH; otherwise stay.
  - FETCH: LDOP=1 on the WTEND clock, and OPC is latched on that edge. Next state is chosen from the OPC value latched on that edge:
    - MPY, DIV or MPH with MDCNT>1 -> STALL;
    - otherwise HOP -> HOPX;
    - otherwise -> EXEC.
  - STALL: STALLO=1. At WTEND, MDCNT<=1 -> EXEC; otherwise stay.
  - EXEC: EXEC=1. At WTEND, PCINC=1. Next state:
    - HALTREQ=1 -> HALT;
    - else INTREQ&INTEN -> INTX;
    - else -> FETCH.
  - HOPX: at WTEND, HOPLD=1 and PCINC=0. Exit priority is the same as EXEC.
  - INTX: at WTEND, INTACK=1 -> FETCH. INTREQ is sampled only at EXEC/HOPX exit and is never re-sampled in INTX.
  - HALT: at WTEND, RUN=1 && HALTREQ=0 -> FETCH.
- Exit priority from EXEC/HOPX: HALTREQ > interrupt > fetch.
- MDCNT:
  - At every WTEND with MDCNT!=0, MDCNT decrements by 1 in any state, including HALT.
  - At WTEND of EXEC with latched MPY, MDCNT loads MPY_CYC; with DIV, it loads DIV_CYC.
  - A load overrides a decrement on the same edge.
  - MPH never loads MDCNT; it only waits.
  - MDBUSY = (MDCNT != 0).
- RUN is ignored outside IDLE/HALT.
- OPC is don't-care except on the LDOP clock.

Test Plan:
- Reset and basic fetch. Stimulus: RSTN low 3 clocks, release at clk 0, RUN=1, OPC=0111. Required response:
  - WTEND at clocks 55, 111, 167.
  - STATE 0->1 after 55; LDOP at 111; STATE=2 after 111; PCINC at 167; then FETCH.
- HOP. Stimulus: OPC=0000 at LDOP. Required response: STATE FETCH->HOPX; HOPLD pulses exactly one word later; no PCINC for that instruction.
- Multiply stall. Stimulus: MPY, then ADD, then MPH. Required response:
  - MDCNT=4 after the MPY EXEC WTEND and decrements each word.
  - MPH fetch sees MDCNT=2 -> STALL one word time, then EXEC.
  - MPY followed directly by MPY stalls 3 word times.
- Interrupt. Stimulus: INTREQ=1 and INTEN=1 during EXEC. Required response: PCINC and INTX entry on the same WTEND; INTACK one word later; then FETCH. With INTEN=0 the request is ignored.
- Halt versus interrupt. Stimulus: HALTREQ=1 and INTREQ=1 at EXEC end. Required response:
  - HALT entered and no INTACK.
  - DIV issued before the halt: MDCNT counts 8->0 while halted.
  - RUN=1 with HALTREQ=0 -> FETCH at next WTEND.
- Mid-instruction reset. Stimulus: RSTN=0 for one edge during STALL with MDCNT=3. Required response: next clock STATE=0, MDCNT=0, BT=0, PHASE=0, all pulses 0.
